// File: rtl/pixel_ray_scheduler_pkg.sv
// Shared fixed-point types and helpers for the pixel ray scheduler.
package pixel_ray_scheduler_pkg;

  localparam int FRAC_BITS = 16;

  typedef logic signed [31:0] fix_t;

  typedef struct packed {
    fix_t x;
    fix_t y;
    fix_t z;
  } vec3_t;

  // Q16.16 multiply: full signed product, keep bits [47:16].
  function automatic fix_t fix_mul(input fix_t a, input fix_t b);
    return fix_t'((64'(a) * 64'(b)) >>> FRAC_BITS);
  endfunction

endpackage

// File: rtl/pixel_ray_scheduler_ray_out_buffer.sv
// Two-entry FIFO holding normalised directions with their pixel coordinates.
// Push and pop in the same cycle are allowed at any occupancy; the caller
// guarantees a push into a full buffer only happens together with a pop.
module ray_out_buffer
  import pixel_ray_scheduler_pkg::*;
#(
  parameter int PXW = 9,
  parameter int PYW = 8
) (
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic           push,
  input  vec3_t          push_dir,
  input  logic [PXW-1:0] push_px,
  input  logic [PYW-1:0] push_py,
  input  logic           pop,
  output vec3_t          head_dir,
  output logic [PXW-1:0] head_px,
  output logic [PYW-1:0] head_py,
  output logic [1:0]     count
);

  vec3_t          dir_mem [2];
  logic [PXW-1:0] px_mem  [2];
  logic [PYW-1:0] py_mem  [2];
  logic           wr_ptr;
  logic           rd_ptr;

  // Storage, pointers and occupancy; cleared so the head reads 0 after reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < 2; i++) begin
        dir_mem[i] <= '0;
        px_mem[i]  <= '0;
        py_mem[i]  <= '0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        dir_mem[wr_ptr] <= push_dir;
        px_mem[wr_ptr]  <= push_px;
        py_mem[wr_ptr]  <= push_py;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + 2'(push) - 2'(pop);
    end
  end

  assign head_dir = dir_mem[rd_ptr];
  assign head_px  = px_mem[rd_ptr];
  assign head_py  = py_mem[rd_ptr];

endmodule

// File: rtl/pixel_ray_scheduler.sv
// Raster-order pixel walker feeding ray_gen and delivering normalised rays
// downstream through a two-entry buffer.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no frame active, waiting for frame_start
// S_ISSUE | pulse ray_gen_start for the current pixel
// S_WAIT  | request in flight, or stalled until the buffer frees a slot
// S_DRAIN | last pixel captured, waiting for the buffer to empty
module pixel_ray_scheduler
  import pixel_ray_scheduler_pkg::*;
#(
  parameter int   H_RES    = 320,
  parameter int   V_RES    = 180,
  parameter fix_t PIX_STEP = 32'h0000_0199,
  parameter fix_t FOCAL    = 32'h0001_0000
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     frame_start,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     ray_gen_start,
  output logic [31:0]              ray_gen_in_x,
  output logic [31:0]              ray_gen_in_y,
  output logic [31:0]              ray_gen_in_z,
  input  logic                     ray_gen_done,
  input  logic [31:0]              ray_gen_out_x,
  input  logic [31:0]              ray_gen_out_y,
  input  logic [31:0]              ray_gen_out_z,
  output logic                     ray_valid_out,
  input  logic                     ray_ready_in,
  output logic [31:0]              ray_dir_x,
  output logic [31:0]              ray_dir_y,
  output logic [31:0]              ray_dir_z,
  output logic [$clog2(H_RES)-1:0] ray_px_x,
  output logic [$clog2(V_RES)-1:0] ray_px_y
);

  localparam int PXW = $clog2(H_RES);
  localparam int PYW = $clog2(V_RES);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DRAIN} state_t;

  state_t         state;
  state_t         state_nxt;
  logic [PXW-1:0] px_cnt;
  logic [PYW-1:0] py_cnt;
  logic [PXW-1:0] px_nxt;
  logic [PYW-1:0] py_nxt;
  logic           in_flight;
  logic           last_pix;
  logic           push;
  logic           pop;
  logic           start_frame;
  logic [1:0]     buf_count;
  vec3_t          req_dir;
  vec3_t          cap_dir;
  vec3_t          head_dir;

  // Unnormalised camera-space direction of a pixel.
  function automatic vec3_t pixel_dir(input logic [PXW-1:0] px, input logic [PYW-1:0] py);
    fix_t  ox;
    fix_t  oy;
    vec3_t d;
    ox  = fix_t'(32'(px)) - fix_t'(H_RES / 2);
    oy  = fix_t'(V_RES / 2) - fix_t'(32'(py));
    d.x = fix_mul(ox <<< FRAC_BITS, PIX_STEP);
    d.y = fix_mul(oy <<< FRAC_BITS, PIX_STEP);
    d.z = FOCAL;
    return d;
  endfunction

  assign last_pix = (px_cnt == PXW'(H_RES - 1)) && (py_cnt == PYW'(V_RES - 1));
  assign pop      = ray_valid_out & ray_ready_in;

  // Raster advance: column wraps to 0 and the row steps.
  always_comb begin
    px_nxt = px_cnt + PXW'(1);
    py_nxt = py_cnt;
    if (px_cnt == PXW'(H_RES - 1)) begin
      px_nxt = '0;
      py_nxt = py_cnt + PYW'(1);
    end
  end

  // State register.
  always_ff @(posedge clk_in) begin
    if (rst_in) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next state and per-cycle strobes; a request is only issued once a free
  // buffer slot is guaranteed for its result.
  always_comb begin
    state_nxt     = state;
    ray_gen_start = 1'b0;
    frame_done    = 1'b0;
    push          = 1'b0;
    start_frame   = 1'b0;
    case (state)
      S_IDLE: begin
        if (frame_start) begin
          start_frame = 1'b1;
          state_nxt   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        ray_gen_start = 1'b1;
        state_nxt     = S_WAIT;
      end
      S_WAIT: begin
        if (in_flight && ray_gen_done) begin
          push = 1'b1;
          if (last_pix)                        state_nxt = S_DRAIN;
          else if (buf_count == 2'd0 || pop)   state_nxt = S_ISSUE;
        end else if (!in_flight && pop) begin
          state_nxt = S_ISSUE;
        end
      end
      S_DRAIN: begin
        if (buf_count == 2'd0) begin
          frame_done = 1'b1;
          state_nxt  = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

  // Pixel counters, in-flight flag and the request operands; operands only
  // change on capture, so they stay stable while a request is outstanding.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      px_cnt    <= '0;
      py_cnt    <= '0;
      in_flight <= 1'b0;
      req_dir   <= '0;
    end else begin
      if (start_frame) begin
        px_cnt  <= '0;
        py_cnt  <= '0;
        req_dir <= pixel_dir('0, '0);
      end else if (push) begin
        px_cnt  <= px_nxt;
        py_cnt  <= py_nxt;
        req_dir <= pixel_dir(px_nxt, py_nxt);
      end
      if (state == S_ISSUE) in_flight <= 1'b1;
      else if (push)        in_flight <= 1'b0;
    end
  end

  assign ray_gen_in_x = req_dir.x;
  assign ray_gen_in_y = req_dir.y;
  assign ray_gen_in_z = req_dir.z;

  assign cap_dir.x = ray_gen_out_x;
  assign cap_dir.y = ray_gen_out_y;
  assign cap_dir.z = ray_gen_out_z;

  ray_out_buffer #(
    .PXW (PXW),
    .PYW (PYW)
  ) u_buf (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .push     (push),
    .push_dir (cap_dir),
    .push_px  (px_cnt),
    .push_py  (py_cnt),
    .pop      (pop),
    .head_dir (head_dir),
    .head_px  (ray_px_x),
    .head_py  (ray_px_y),
    .count    (buf_count)
  );

  assign ray_valid_out = (buf_count != 2'd0);
  assign ray_dir_x     = head_dir.x;
  assign ray_dir_y     = head_dir.y;
  assign ray_dir_z     = head_dir.z;

endmodule

// File: tb/tb_pixel_ray_scheduler.sv
// Scoreboard bench: expected rays are queued when a frame is started and a
// monitor pops and compares every ray accepted downstream.
module tb_pixel_ray_scheduler;

  localparam int          H    = 4;
  localparam int          V    = 2;
  localparam logic [31:0] STEP = 32'h0001_0000;
  localparam logic [31:0] FOC  = 32'h0001_0000;
  localparam int          PXW  = $clog2(H);
  localparam int          PYW  = $clog2(V);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic           frame_start = 1'b0;
  logic           busy, frame_done, ray_gen_start;
  logic [31:0]    ray_gen_in_x, ray_gen_in_y, ray_gen_in_z;
  logic           ray_gen_done = 1'b0;
  logic [31:0]    ray_gen_out_x = '0, ray_gen_out_y = '0, ray_gen_out_z = '0;
  logic           ray_valid_out;
  logic           ray_ready_in = 1'b1;
  logic [31:0]    ray_dir_x, ray_dir_y, ray_dir_z;
  logic [PXW-1:0] ray_px_x;
  logic [PYW-1:0] ray_px_y;

  pixel_ray_scheduler #(.H_RES(H), .V_RES(V), .PIX_STEP(STEP), .FOCAL(FOC)) dut (
    .clk_in(clk), .rst_in(rst), .frame_start(frame_start), .busy(busy),
    .frame_done(frame_done), .ray_gen_start(ray_gen_start),
    .ray_gen_in_x(ray_gen_in_x), .ray_gen_in_y(ray_gen_in_y), .ray_gen_in_z(ray_gen_in_z),
    .ray_gen_done(ray_gen_done), .ray_gen_out_x(ray_gen_out_x),
    .ray_gen_out_y(ray_gen_out_y), .ray_gen_out_z(ray_gen_out_z),
    .ray_valid_out(ray_valid_out), .ray_ready_in(ray_ready_in),
    .ray_dir_x(ray_dir_x), .ray_dir_y(ray_dir_y), .ray_dir_z(ray_dir_z),
    .ray_px_x(ray_px_x), .ray_px_y(ray_px_y));

  // Default-parameter instance, used only for the first-pixel direction.
  logic        d_fs = 1'b0;
  logic        d_busy, d_done, d_start, d_valid;
  logic [31:0] d_in_x, d_in_y, d_in_z, d_dx, d_dy, d_dz;
  logic [8:0]  d_px;
  logic [7:0]  d_py;

  pixel_ray_scheduler dut_def (
    .clk_in(clk), .rst_in(rst), .frame_start(d_fs), .busy(d_busy),
    .frame_done(d_done), .ray_gen_start(d_start),
    .ray_gen_in_x(d_in_x), .ray_gen_in_y(d_in_y), .ray_gen_in_z(d_in_z),
    .ray_gen_done(1'b0), .ray_gen_out_x(32'h0), .ray_gen_out_y(32'h0), .ray_gen_out_z(32'h0),
    .ray_valid_out(d_valid), .ray_ready_in(1'b1),
    .ray_dir_x(d_dx), .ray_dir_y(d_dy), .ray_dir_z(d_dz),
    .ray_px_x(d_px), .ray_px_y(d_py));

  typedef struct {
    logic [31:0] x, y, z;
    int          px, py;
  } ray_t;

  ray_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   pops  = 0;
  int   fd_cnt = 0;
  int   start_cnt = 0;
  int   ready_mode = 0;

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endfunction

  // Reference direction from the pixel coordinate rules, plain integer math.
  function automatic ray_t ref_ray(input int px, input int py, input int hr, input int vr,
                                   input longint step, input logic [31:0] foc);
    ray_t r;
    r.x  = 32'(longint'(px - hr / 2) * step);
    r.y  = 32'(longint'(vr / 2 - py) * step);
    r.z  = foc;
    r.px = px;
    r.py = py;
    return r;
  endfunction

  function automatic void queue_frame();
    for (int py = 0; py < V; py++)
      for (int px = 0; px < H; px++)
        exp_q.push_back(ref_ray(px, py, H, V, longint'(STEP), FOC));
  endfunction

  // ray_gen model: done 5 cycles after start, out = in.
  initial begin
    int          cnt = 0;
    bit          stale = 1'b0;
    logic [31:0] cx = '0, cy = '0, cz = '0;
    forever begin
      @(posedge clk); #1;
      ray_gen_done = 1'b0;
      if (rst) stale = 1'b1;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          ray_gen_done  = 1'b1;
          ray_gen_out_x = cx;
          ray_gen_out_y = cy;
          ray_gen_out_z = cz;
          if (!stale) begin
            chk("rg_in_stable_x", ray_gen_in_x, cx);
            chk("rg_in_stable_y", ray_gen_in_y, cy);
          end
        end
      end
      if (ray_gen_start) begin
        start_cnt++;
        cx = ray_gen_in_x; cy = ray_gen_in_y; cz = ray_gen_in_z;
        cnt = 5;
        stale = 1'b0;
      end
    end
  end

  // Downstream ready pattern: 0 always, 1 held low, 2 toggle, 3 random.
  initial begin
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       ray_ready_in = 1'b1;
        1:       ray_ready_in = 1'b0;
        2:       ray_ready_in = ~ray_ready_in;
        default: ray_ready_in = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: compare every accepted ray and every frame_done pulse.
  initial begin
    ray_t r;
    forever begin
      @(negedge clk);
      if (!rst && ray_valid_out && ray_ready_in) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_ray got px=%0d py=%0d want none", ray_px_x, ray_px_y);
        end else begin
          r = exp_q.pop_front();
          pops++;
          chk("ray_dir_x", ray_dir_x, r.x);
          chk("ray_dir_y", ray_dir_y, r.y);
          chk("ray_dir_z", ray_dir_z, r.z);
          chk("ray_px_x", 32'(ray_px_x), 32'(r.px));
          chk("ray_px_y", 32'(ray_px_y), 32'(r.py));
        end
      end
      if (!rst && frame_done) begin
        fd_cnt++;
        chk("frame_done_pending_rays", 32'(exp_q.size()), 32'd0);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_start(input bit accepted);
    frame_start = 1'b1;
    if (accepted) queue_frame();
    tick(1);
    frame_start = 1'b0;
  endtask

  task automatic wait_rg_start(input string tag);
    int n = 0;
    while (!ray_gen_start && n < 50) begin tick(1); n++; end
    total++;
    if (!ray_gen_start) begin
      bad++;
      $display("FAIL %s_start_timeout got=0 want=1", tag);
    end
  endtask

  task automatic wait_frame(input string tag);
    int n = 0;
    int fd0 = fd_cnt;
    int p0 = pops;
    while (fd_cnt == fd0 && n < 3000) begin tick(1); n++; end
    tick(4);
    chk({tag, "_frame_done_count"}, 32'(fd_cnt - fd0), 32'd1);
    chk({tag, "_busy_after"}, 32'(busy), 32'd0);
    chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    if (p0 >= 0) chk({tag, "_ray_count"}, 32'(pops - p0), 32'(exp_q.size() == 0 ? pops - p0 : -1));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    chk({tag, "_rg_start"}, 32'(ray_gen_start), 32'd0);
    chk({tag, "_rg_in_x"}, ray_gen_in_x, 32'd0);
    chk({tag, "_rg_in_y"}, ray_gen_in_y, 32'd0);
    chk({tag, "_rg_in_z"}, ray_gen_in_z, 32'd0);
    chk({tag, "_valid"}, 32'(ray_valid_out), 32'd0);
    chk({tag, "_dir_x"}, ray_dir_x, 32'd0);
    chk({tag, "_dir_z"}, ray_dir_z, 32'd0);
    chk({tag, "_px"}, 32'({ray_px_y, ray_px_x}), 32'd0);
  endtask

  initial begin
    ray_t r0, rl, rd;
    int   s0, p0, fd0, n, seen;
    r0 = ref_ray(0, 0, H, V, longint'(STEP), FOC);
    rl = ref_ray(H - 1, V - 1, H, V, longint'(STEP), FOC);
    rd = ref_ray(0, 0, 320, 180, 64'h199, 32'h0001_0000);

    tick(3);
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset");

    // Default parameters: first pixel direction.
    tick(1);
    d_fs = 1'b1; tick(1); d_fs = 1'b0;
    n = 0;
    while (!d_start && n < 20) begin tick(1); n++; end
    chk("def_in_x", d_in_x, rd.x);
    chk("def_in_y", d_in_y, rd.y);
    chk("def_in_z", d_in_z, rd.z);

    // Frame with ready always high; first and last requests checked directly.
    pulse_start(1'b1);
    wait_rg_start("first");
    chk("first_in_x", ray_gen_in_x, r0.x);
    chk("first_in_y", ray_gen_in_y, r0.y);
    chk("first_in_z", ray_gen_in_z, r0.z);
    n = 0;
    while (start_cnt < 8 && n < 200) begin tick(1); n++; end
    wait_rg_start("last");
    chk("last_in_x", ray_gen_in_x, rl.x);
    chk("last_in_y", ray_gen_in_y, rl.y);
    wait_frame("plain");

    // Downstream held off for 40 cycles: buffer fills and requests stall.
    ready_mode = 1;
    tick(2);
    s0 = start_cnt;
    p0 = pops;
    pulse_start(1'b1);
    tick(40);
    chk("hold_starts", 32'(start_cnt - s0), 32'd2);
    chk("hold_valid", 32'(ray_valid_out), 32'd1);
    chk("hold_no_pops", 32'(pops - p0), 32'd0);
    ready_mode = 0;
    wait_frame("hold");
    chk("hold_total_rays", 32'(pops - p0), 32'(H * V));

    // Ready toggling every cycle.
    ready_mode = 2;
    p0 = pops;
    pulse_start(1'b1);
    wait_frame("toggle");
    chk("toggle_total_rays", 32'(pops - p0), 32'(H * V));

    // Random ready with frame_start pulses while busy.
    ready_mode = 3;
    p0 = pops;
    pulse_start(1'b1);
    tick(20);
    chk("busy_mid_frame", 32'(busy), 32'd1);
    pulse_start(1'b0);
    tick(9);
    pulse_start(1'b0);
    wait_frame("busy_start");
    chk("busy_start_total_rays", 32'(pops - p0), 32'(H * V));

    // Reset while a request is in flight.
    ready_mode = 0;
    p0 = pops;
    fd0 = fd_cnt;
    pulse_start(1'b1);
    n = 0;
    while (pops < p0 + 3 && n < 300) begin tick(1); n++; end
    wait_rg_start("pre_reset");
    tick(2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("midreset");
    exp_q.delete();
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (ray_valid_out || ray_gen_start || busy || frame_done) seen++;
    end
    chk("late_done_ignored", 32'(seen), 32'd0);
    chk("reset_no_frame_done", 32'(fd_cnt - fd0), 32'd0);
    tick(1);
    p0 = pops;
    pulse_start(1'b1);
    wait_rg_start("restart");
    chk("restart_in_x", ray_gen_in_x, r0.x);
    chk("restart_in_y", ray_gen_in_y, r0.y);
    wait_frame("restart");
    chk("restart_total_rays", 32'(pops - p0), 32'(H * V));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
